// File: rtl/demux1_4_stream_pkg.sv
// Shared lane-select constants and helpers for the 1-to-4 stream demultiplexer.
package demux1_4_stream_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SEL_ZERO  = 2'd0;
    localparam logic [1:0] SEL_ONE   = 2'd1;
    localparam logic [1:0] SEL_TWO   = 2'd2;
    localparam logic [1:0] SEL_THREE = 2'd3;

    // One-hot decode of a lane select.
    function automatic logic [LANES-1:0] sel_onehot(input logic [1:0] sel);
        logic [LANES-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry register slice for one output lane: a word is loaded when the
// top accepts it for this lane, and is dropped when the consumer takes it.
// can_load lets the slice take a new word in the same cycle the old one drains.
module demux_slot
    import demux1_4_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             can_load
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Flush beats load beats drain; data is only written on load and never cleared by drain or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid    = r_valid;
    assign data     = r_data;
    assign can_load = !r_valid || ready;

endmodule

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer. Each word is steered by in_sel
// into one of four independent single-entry lane slices; a stalled lane only
// blocks input words that select it.
module demux1_4_stream
    import demux1_4_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_zero,
    output logic [WIDTH-1:0] out_one,
    output logic [WIDTH-1:0] out_two,
    output logic [WIDTH-1:0] out_three
);

    logic [LANES-1:0] w_can_load;
    logic [LANES-1:0] w_load;
    logic [LANES-1:0] w_valid;
    logic [WIDTH-1:0] w_data [LANES];
    logic             w_accept;

    // Ready depends only on the selected lane, never on in_valid.
    assign in_ready = !flush && w_can_load[in_sel];
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept ? sel_onehot(in_sel) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .load      (w_load[gi]),
                .load_data (in_data),
                .valid     (w_valid[gi]),
                .ready     (out_ready[gi]),
                .data      (w_data[gi]),
                .can_load  (w_can_load[gi])
            );
        end
    endgenerate

    assign out_valid = w_valid;
    assign out_zero  = w_data[SEL_ZERO];
    assign out_one   = w_data[SEL_ONE];
    assign out_two   = w_data[SEL_TWO];
    assign out_three = w_data[SEL_THREE];

endmodule

// File: tb/tb_demux1_4_stream.sv
// Bench for demux1_4_stream: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_demux1_4_stream;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_zero;
    logic [31:0] out_one;
    logic [31:0] out_two;
    logic [31:0] out_three;

    int checks   = 0;
    int failures = 0;

    demux1_4_stream #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_zero  (out_zero),
        .out_one   (out_one),
        .out_two   (out_two),
        .out_three (out_three)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each lane is a queue of words waiting for its consumer, plus
    // the last word ever written to that lane (what the data port shows).
    logic [31:0] m_q [4][$];
    logic [31:0] m_last [4];
    int          m_drained  = 0;
    int          dut_drains = 0;

    function automatic logic m_in_ready();
        return !flush && ((m_q[in_sel].size() == 0) || out_ready[in_sel]);
    endfunction

    function automatic logic [3:0] m_out_valid();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = (m_q[n].size() != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every edge, from the values the DUT also samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                m_q[n].delete();
                m_last[n] = '0;
            end
        end else begin
            logic acc;
            acc = in_valid && m_in_ready();
            for (int n = 0; n < 4; n++) begin
                if (out_ready[n] && m_q[n].size() != 0) begin
                    void'(m_q[n].pop_front());
                    if (!flush) m_drained++;
                end
            end
            if (flush) begin
                for (int n = 0; n < 4; n++) m_q[n].delete();
            end else if (acc) begin
                m_q[in_sel].push_back(in_data);
                m_last[in_sel] = in_data;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_out_valid", {28'd0, out_valid}, {28'd0, m_out_valid()});
            chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_in_ready()});
            chk("cyc_out_zero", out_zero, m_last[0]);
            chk("cyc_out_one", out_one, m_last[1]);
            chk("cyc_out_two", out_two, m_last[2]);
            chk("cyc_out_three", out_three, m_last[3]);
            if (!flush) dut_drains += $countones(out_valid & out_ready);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step();
        in_valid = 1'b0;
        $display("sent lane=%0d data=%h out_valid=%b", sel, d, out_valid);
    endtask

    initial begin
        logic acc_prev;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 4'b0000;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset: lane 2 holds DEADBEEF, asynchronous reset mid-cycle clears it.
        send(2'd2, 32'hDEADBEEF);
        chk("rst_pre_valid", {28'd0, out_valid}, 32'h4);
        chk("rst_pre_two", out_two, 32'hDEADBEEF);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_async_two", out_two, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        step();

        // Single route to lane 2 with consumer ready.
        out_ready = 4'b0100;
        send(2'd2, 32'h0000_00A5);
        chk("route_valid", {28'd0, out_valid}, 32'h4);
        chk("route_two", out_two, 32'hA5);
        step();
        chk("route_drained", {28'd0, out_valid}, 32'h0);

        // Back-pressure isolation: lane 1 stalled, lane 3 still reachable.
        out_ready = 4'b0000;
        send(2'd1, 32'h11);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h11;
        #1;
        chk("bp_blocked", {31'd0, in_ready}, 32'h0);
        step();
        chk("bp_hold_one", out_one, 32'h11);
        chk("bp_hold_valid", {28'd0, out_valid}, 32'h2);
        in_sel  = 2'd3;
        in_data = 32'h33;
        #1;
        chk("bp_other_ready", {31'd0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        $display("sent lane=3 data=00000033 out_valid=%b", out_valid);
        chk("bp_three", out_three, 32'h33);
        chk("bp_valid13", {28'd0, out_valid}, 32'hA);
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        chk("bp_drained", {28'd0, out_valid}, 32'h0);

        // Streaming 1..8 back-to-back into lane 0.
        out_ready = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_data  = i;
            #1;
            chk("stream_ready", {31'd0, in_ready}, 32'h1);
            step();
            $display("stream word %0d out_zero=%h", i, out_zero);
            chk("stream_zero", out_zero, i);
            chk("stream_valid", {28'd0, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end", {28'd0, out_valid}, 32'h0);

        // Flush priority over a pending accept.
        out_ready = 4'b0000;
        send(2'd0, 32'hA0);
        send(2'd3, 32'hA3);
        chk("flush_pre", {28'd0, out_valid}, 32'h9);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'hBAD;
        #1;
        chk("flush_ready", {31'd0, in_ready}, 32'h0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {28'd0, out_valid}, 32'h0);
        chk("flush_zero_kept", out_zero, 32'hA0);
        chk("flush_three_kept", out_three, 32'hA3);

        // Randomized traffic obeying valid/ready hold rules.
        acc_prev = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || acc_prev) begin
                in_valid = ($urandom_range(0, 99) < 60);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = $urandom;
            end
            out_ready = 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 99) < 2);
            #1;
            acc_prev = in_valid && m_in_ready();
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 4'b0000;
        step();
        $display("random phase drains dut=%0d model=%0d", dut_drains, m_drained);
        chk("drain_count", dut_drains, m_drained);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
